// File: rtl/feature_map_streamer.sv
// Snapshots a flattened feature map on start and streams it one value per cycle
// over valid/ready, channel-planar raster order (channel, then row, then column).
//
// state  | meaning
// IDLE   | no frame; outputs zero, waiting for start
// STREAM | presenting snapshot[(row*OUT_DIM+col)*biasWidth+ch]; advances on each transfer
module feature_map_streamer #(
    parameter int bitWidth   = 17,
    parameter int inputWidth = 8,
    parameter int biasWidth  = 2,
    localparam int OUT_DIM   = inputWidth / 2,
    localparam int MAP_SIZE  = OUT_DIM * OUT_DIM * biasWidth,
    localparam int CH_W      = (biasWidth > 1) ? $clog2(biasWidth) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [bitWidth-1:0] featureMap [MAP_SIZE],
    output logic signed [bitWidth-1:0] outPixel,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [CH_W-1:0]            outChannel,
    output logic                       outFirst,
    output logic                       outLast,
    output logic                       frameDone,
    output logic                       busy,
    output logic                       overrun
);
    localparam int POS_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int IDX_W = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(OUT_DIM - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(biasWidth - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state;
    logic [POS_W-1:0]           row;
    logic [POS_W-1:0]           col;
    logic [CH_W-1:0]            ch;
    logic signed [bitWidth-1:0] snapshot [MAP_SIZE];
    logic                       frame_done;
    logic                       sticky_overrun;
    logic                       at_end;
    logic                       streaming;
    logic [IDX_W-1:0]           idx;

    assign streaming = (state == STREAM);
    assign at_end    = (ch == CH_LAST) && (row == POS_LAST) && (col == POS_LAST);
    assign idx       = (IDX_W'(row) * IDX_W'(OUT_DIM) + IDX_W'(col)) * IDX_W'(biasWidth)
                       + IDX_W'(ch);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            row            <= '0;
            col            <= '0;
            ch             <= '0;
            frame_done     <= 1'b0;
            sticky_overrun <= 1'b0;
            for (int i = 0; i < MAP_SIZE; i++) snapshot[i] <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snapshot <= featureMap;
                        row      <= '0;
                        col      <= '0;
                        ch       <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    // Only a start landing on the final transfer can be honoured.
                    if (start && !(outReady && at_end)) sticky_overrun <= 1'b1;
                    if (outReady) begin
                        if (at_end) begin
                            frame_done <= 1'b1;
                            row        <= '0;
                            col        <= '0;
                            ch         <= '0;
                            if (start) snapshot <= featureMap;
                            else       state    <= IDLE;
                        end else if (col == POS_LAST) begin
                            col <= '0;
                            if (row == POS_LAST) begin
                                row <= '0;
                                ch  <= ch + 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = streaming;
    assign outValid   = streaming;
    assign outPixel   = streaming ? snapshot[idx] : '0;
    assign outChannel = streaming ? ch : '0;
    assign outFirst   = streaming && (row == '0) && (col == '0);
    assign outLast    = streaming && (row == POS_LAST) && (col == POS_LAST);
    assign frameDone  = frame_done;
    assign overrun    = sticky_overrun;
endmodule

// File: tb/tb_feature_map_streamer.sv
// Self-checking bench for feature_map_streamer: vector table for the plain frame,
// reference-model receiver for backpressure, collisions, isolation and resets.
module tb_feature_map_streamer;
    localparam int BW      = 17;
    localparam int OUT_DIM = 4;
    localparam int NCH     = 2;
    localparam int PER_CH  = OUT_DIM * OUT_DIM;
    localparam int MAP     = PER_CH * NCH;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic signed [BW-1:0] feature_map [MAP];
    logic signed [BW-1:0] out_pixel;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:0]           out_channel;
    logic                 out_first;
    logic                 out_last;
    logic                 frame_done;
    logic                 busy;
    logic                 overrun;

    int checks   = 0;
    int failures = 0;

    logic signed [BW-1:0] base_map [MAP];
    logic signed [BW-1:0] ref_map  [MAP];
    logic signed [BW-1:0] map2     [MAP];

    typedef struct {
        bit                   ready;
        bit                   valid;
        logic signed [BW-1:0] pixel;
        logic [0:0]           ch;
        bit                   first;
        bit                   last;
        bit                   done;
        bit                   busy;
    } vec_t;
    vec_t vecs [MAP+1];

    feature_map_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .featureMap (feature_map),
        .outPixel   (out_pixel),
        .outValid   (out_valid),
        .outReady   (out_ready),
        .outChannel (out_channel),
        .outFirst   (out_first),
        .outLast    (out_last),
        .frameDone  (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // i-th transfer of a frame: channel-major, then row, then column.
    function automatic logic signed [BW-1:0] exp_pix(input int i);
        int c, pos;
        c   = i / PER_CH;
        pos = i % PER_CH;
        return ref_map[((pos / OUT_DIM) * OUT_DIM + (pos % OUT_DIM)) * NCH + c];
    endfunction

    function automatic int exp_ch(input int i);
        return i / PER_CH;
    endfunction

    function automatic int exp_first(input int i);
        return ((i % PER_CH) == 0) ? 1 : 0;
    endfunction

    function automatic int exp_last(input int i);
        return ((i % PER_CH) == PER_CH - 1) ? 1 : 0;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pixel"}, out_pixel, 0);
        chk({tag, "_ch"}, out_channel, 0);
        chk({tag, "_first"}, out_first, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    // Leaves the bench at the negedge where the first pixel is visible.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes a frame from the current negedge, checking every transfer against
    // the model. hold_idx: stall 5 cycles on that element; start_idx: pulse start
    // together with that transfer; max_rx: stop early after that many transfers.
    task automatic receive(input int hold_idx, input bit rnd, input int start_idx,
                           input int max_rx);
        int n_rx = 0;
        int hold_left = 5;
        int fd = 0;
        bit started = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (frame_done && cyc > 0) begin
                fd++;
                chk("done_timing", n_rx, MAP);
            end
            if (n_rx == max_rx && (max_rx < MAP || fd > 0)) break;
            start     = 1'b0;
            out_ready = rnd ? 1'($urandom % 2) : 1'b1;
            if (n_rx == hold_idx && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
                chk("hold_pixel", out_pixel, exp_pix(hold_idx));
                chk("hold_valid", out_valid, 1);
            end
            if (n_rx == start_idx && !started) begin
                start     = 1'b1;
                out_ready = 1'b1;
                started   = 1'b1;
            end
            if (out_valid && out_ready) begin
                chk("rx_pixel", out_pixel, exp_pix(n_rx));
                chk("rx_ch", out_channel, exp_ch(n_rx));
                chk("rx_first", out_first, exp_first(n_rx));
                chk("rx_last", out_last, exp_last(n_rx));
                n_rx++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("rx_count", n_rx, max_rx);
        if (max_rx == MAP) chk("done_seen", fd, 1);
    endtask

    task automatic finish_frame_checks();
        chk("end_busy", busy, 0);
        chk("end_valid", out_valid, 0);
        @(negedge clk);
        chk("done_pulse_len", frame_done, 0);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < MAP; i++) begin
            base_map[i]    = BW'(i + 1);
            feature_map[i] = '0;
        end
        base_map[0] = -17'sd5;
        ref_map     = base_map;
        for (int k = 0; k < MAP; k++)
            vecs[k] = '{ready: 1'b1, valid: 1'b1, pixel: exp_pix(k), ch: 1'(exp_ch(k)),
                        first: exp_first(k) != 0, last: exp_last(k) != 0,
                        done: 1'b0, busy: 1'b1};
        vecs[MAP] = '{ready: 1'b1, valid: 1'b0, pixel: '0, ch: '0, first: 1'b0,
                      last: 1'b0, done: 1'b1, busy: 1'b0};

        // Reset held with random inputs
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start     = 1'($urandom % 2);
            out_ready = 1'($urandom % 2);
            for (int i = 0; i < MAP; i++) feature_map[i] = BW'($urandom);
            check_idle_zero("in_reset");
        end
        @(negedge clk);
        start       = 1'b0;
        feature_map = base_map;
        reset       = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle_zero("post_reset");
            chk("post_reset_done", frame_done, 0);
            chk("post_reset_overrun", overrun, 0);
        end

        // Basic frame from the vector table
        do_start();
        for (int k = 0; k <= MAP; k++) begin
            out_ready = vecs[k].ready;
            chk("vec_valid", out_valid, vecs[k].valid);
            chk("vec_pixel", out_pixel, vecs[k].pixel);
            chk("vec_ch", out_channel, vecs[k].ch);
            chk("vec_first", out_first, vecs[k].first);
            chk("vec_last", out_last, vecs[k].last);
            chk("vec_done", frame_done, vecs[k].done);
            chk("vec_busy", busy, vecs[k].busy);
            @(negedge clk);
        end
        chk("basic_done_len", frame_done, 0);
        chk("basic_overrun", overrun, 0);

        // Backpressure: stall on value 5, then random ready
        do_start();
        receive(2, 1'b1, -1, MAP);
        finish_frame_checks();

        // Snapshot isolation: producer overwrites right after start
        do_start();
        for (int i = 0; i < MAP; i++) feature_map[i] = 17'h1FFFF;
        receive(-1, 1'b0, -1, MAP);
        finish_frame_checks();

        // Start coincident with the final transfer: back-to-back frames
        feature_map = base_map;
        for (int i = 0; i < MAP; i++) map2[i] = BW'($urandom);
        do_start();
        feature_map = map2;
        receive(-1, 1'b0, MAP - 1, MAP);
        chk("b2b_done", frame_done, 1);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_overrun", overrun, 0);
        ref_map = map2;
        chk("b2b_first_pixel", out_pixel, exp_pix(0));
        chk("b2b_first_flag", out_first, 1);
        receive(-1, 1'b1, -1, MAP);
        finish_frame_checks();
        chk("b2b_overrun_end", overrun, 0);

        // Start during the 10th transfer is dropped
        feature_map = base_map;
        ref_map     = base_map;
        do_start();
        receive(-1, 1'b0, 9, MAP);
        chk("overrun_set", overrun, 1);
        finish_frame_checks();

        // Random map, random ready; overrun must stay sticky
        for (int i = 0; i < MAP; i++) feature_map[i] = BW'($urandom);
        ref_map = feature_map;
        do_start();
        receive(-1, 1'b1, -1, MAP);
        finish_frame_checks();
        chk("overrun_sticky", overrun, 1);

        // Asynchronous reset mid-stream
        feature_map = base_map;
        ref_map     = base_map;
        do_start();
        receive(-1, 1'b0, -1, 7);
        #2 reset = 1'b0;
        #1;
        check_idle_zero("async_reset");
        chk("async_reset_overrun", overrun, 0);
        chk("async_reset_done", frame_done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_start();
        chk("restart_pixel", out_pixel, -5);
        chk("restart_first", out_first, 1);
        chk("restart_valid", out_valid, 1);
        receive(-1, 1'b0, -1, MAP);
        finish_frame_checks();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/feature_map_streamer.md
Name: feature_map_streamer

Overview:
- Reader for the parallel feature-map array that the 2D convolution/ReLU layer fills.
- On a start pulse it snapshots the whole flattened map into a local buffer, then streams it one value per cycle over a valid/ready handshake.
- Stream order is channel-planar raster, the pixel-serial form the next convolution layer consumes.
- Decouples the producer, which may overwrite its array immediately, from downstream backpressure.

Parameters:
- bitWidth, 17, signed fixed-point word width.
- inputWidth, 8, side length of the convolution input; map side OUT_DIM = inputWidth/2 (stride 2).
- biasWidth, 2, number of filters/channels (≥1).
- Derived: MAP_SIZE = OUT_DIM*OUT_DIM*biasWidth; CH_W = max(1, $clog2(biasWidth)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: map is complete and valid.
- featureMap  in  signed [bitWidth-1:0] x MAP_SIZE (unpacked)  flattened map; element (row,col,ch) at index (row*OUT_DIM+col)*biasWidth+ch.
- outPixel  out  signed [bitWidth-1:0]  current streamed value.
- outValid  out  1  outPixel valid.
- outReady  in  1  downstream accepts; transfer = outValid && outReady.
- outChannel  out  CH_W  channel of outPixel.
- outFirst  out  1  outPixel is (row 0, col 0) of its channel.
- outLast  out  1  outPixel is (OUT_DIM-1, OUT_DIM-1) of its channel.
- frameDone  out  1  one-cycle pulse after final transfer of a frame.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: a start was dropped.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; counters 0; snapshot cleared to 0.
- States: IDLE, STREAM.
- IDLE: busy=0, outValid=0. On start=1, capture the full featureMap into the snapshot at that edge, clear ch/row/col counters, and go to STREAM. outValid=1 the next cycle (latency 1).
- STREAM: busy=1, outValid=1.
  - outPixel = snapshot[(row*OUT_DIM+col)*biasWidth+ch], driven from registered state.
  - outPixel, outChannel, outFirst and outLast stay stable while outReady=0.
  - Each transfer advances col, wrapping to 0 and incrementing row; row wraps to 0 and increments ch.
  - Order: ch outer, row middle, col inner.
- Final transfer (ch=biasWidth-1, row=col=OUT_DIM-1):
  - Without start: go to IDLE; frameDone=1 for exactly the next cycle.
  - With start in the same cycle: accept it, re-snapshot, reset counters, remain in STREAM (no bubble). frameDone still pulses; overrun unchanged.
- Start in STREAM at any other cycle: ignored; snapshot untouched; overrun set to 1 and held until reset.
- When outValid=0: outPixel, outChannel, outFirst and outLast are 0.
- Values pass unmodified, full signed width, no saturation or rescaling.
- After a snapshot, featureMap changes have no effect on the current frame.
- Exactly MAP_SIZE transfers per frame; no drops or duplicates under any outReady pattern.
- Throughput: MAP_SIZE cycles per frame when outReady=1 throughout.

Test Plan:
Defaults (OUT_DIM=4, MAP_SIZE=32); featureMap[i]=i+1 except featureMap[0]=-5 (0x1FFFB).
- Reset: hold reset=0 with random inputs, then release → all outputs 0, busy=0, and outValid stays 0 with no start.
- Basic stream, outReady=1, start at cycle T:
  - outValid=1 from T+1.
  - Values -5,3,5,…,31 (ch0), then 2,4,…,32 (ch1).
  - outFirst on -5 and 2; outLast on 31 and 32; outChannel 0 for the first 16, 1 for the last 16.
  - frameDone pulses at T+33; busy=0 at T+33.
- Backpressure: outReady=0 for 5 cycles while outPixel=5, then random 50% toggling → 5 held stable for those cycles; received sequence identical to the basic case.
- Snapshot isolation: one cycle after start, set all featureMap to 0x1FFFF → stream still matches the basic case.
- Start collisions:
  - start pulse at the 10th transfer → ignored, overrun=1 for the rest of the test, stream unchanged.
  - In a fresh run, start coincident with the final transfer → second frame's first pixel appears the next cycle, frameDone pulses once, overrun=0.
- Reset mid-stream: drive reset=0 asynchronously after the 7th transfer → outputs 0 before the next edge. After release, a new start streams from element 0 (-5) with outFirst=1.
